// File: rtl/dff_sync.sv
// dff_sync: rising-edge D flip-flop with a synchronous active-low reset and
// true and complemented outputs. Works as a retiming bit or as a small register.
//
// Parameters:
//   WIDTH        data width of i_d, o_q and o_qb
//   RESET_VALUE  value loaded into the register when reset is sampled low
//
// Ports:
//   clk    in   1      clock; all state changes occur on its rising edge
//   reset  in   1      synchronous reset, active low, sampled only at the edge
//   i_d    in   WIDTH  data input, sampled at the rising edge of clk
//   o_q    out  WIDTH  registered data
//   o_qb   out  WIDTH  bitwise complement of o_q (combinational from the register)
`timescale 1ns/1ps

module dff_sync #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qb
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next state: reset wins over data. Reset only matters where it is sampled.
    always_comb begin
        q_d = i_d;
        if (!reset) begin
            q_d = RESET_VALUE;
        end
    end

    // State register. It has no asynchronous path, so a reset pulse between edges is ignored.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    // The complement comes straight from the register, so it can never disagree with o_q.
    assign o_q  = q_q;
    assign o_qb = ~q_q;

endmodule

// File: tb/tb_dff_sync.sv
`timescale 1ns/1ps

module tb_dff_sync;

    logic       clk;
    logic       reset;
    logic       d1;
    logic       q1;
    logic       qb1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int total;
    int bad;

    typedef struct {
        logic       e1;
        logic [7:0] e8;
    } exp_t;

    exp_t sb[$];

    dff_sync u_dut1 (
        .clk   (clk),
        .reset (reset),
        .i_d   (d1),
        .o_q   (q1),
        .o_qb  (qb1)
    );

    dff_sync #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .i_d   (d8),
        .o_q   (q8),
        .o_qb  (qb8)
    );

    // Period 2: rising edges at 1, 3, 5, ...; falling edges at 2, 4, ...
    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Drive inputs and queue the result expected after the next rising edge.
    task automatic drive(input logic rst, input logic d, input logic [7:0] dw);
        exp_t e;
        reset = rst;
        d1    = d;
        d8    = dw;
        e.e1  = rst ? d : 1'b0;
        e.e8  = rst ? dw : 8'hA5;
        sb.push_back(e);
    endtask

    // Wait until the next falling edge, after the rising edge, then compare with the oldest entry.
    task automatic check(input string name);
        exp_t e;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (q1 !== e.e1) begin
            bad++;
            $display("FAIL %s q1: got %b want %b", name, q1, e.e1);
        end
        total++;
        if (qb1 !== ~e.e1) begin
            bad++;
            $display("FAIL %s qb1: got %b want %b", name, qb1, ~e.e1);
        end
        total++;
        if (q8 !== e.e8) begin
            bad++;
            $display("FAIL %s q8: got %h want %h", name, q8, e.e8);
        end
        total++;
        if (qb8 !== ~e.e8) begin
            bad++;
            $display("FAIL %s qb8: got %h want %h", name, qb8, ~e.e8);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 8'hFF);
        check("reset_override");
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 8'h3C);
        check("load_one");
        drive(1'b1, 1'b0, 8'hC3);
        check("load_zero");
    endtask

    task automatic test_glitch();
        logic [1:0] seen;
        drive(1'b1, 1'b0, 8'h00);
        check("glitch_pre");
        // i_d pulses away from 1 between edges and returns before the edge.
        drive(1'b1, 1'b1, 8'h81);
        #0.3 d1 = 1'b0; d8 = 8'h7E;
        #0.1 seen[0] = q1;
        #0.2 d1 = 1'b1; d8 = 8'h81;
        total++;
        if (seen[0] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_mid_rise: got %b want 0", seen[0]);
        end
        check("glitch_rise");
        // Same pattern in the opposite direction.
        drive(1'b1, 1'b0, 8'h18);
        #0.3 d1 = 1'b1; d8 = 8'hE7;
        #0.1 seen[1] = q1;
        #0.2 d1 = 1'b0; d8 = 8'h18;
        total++;
        if (seen[1] !== 1'b1) begin
            bad++;
            $display("FAIL glitch_mid_fall: got %b want 1", seen[1]);
        end
        check("glitch_fall");
    endtask

    task automatic test_sync_reset();
        logic mid;
        drive(1'b1, 1'b1, 8'h5A);
        check("sync_pre");
        // Reset goes low and comes back high between two rising edges. The expected value still comes from reset=1.
        drive(1'b1, 1'b1, 8'h5A);
        #0.2 reset = 1'b0;
        #0.2 mid = q1;
        #0.2 reset = 1'b1;
        total++;
        if (mid !== 1'b1) begin
            bad++;
            $display("FAIL sync_mid: got %b want 1", mid);
        end
        check("sync_hold");
    endtask

    task automatic test_random();
        logic       r;
        logic       d;
        logic [7:0] dw;
        for (int i = 0; i < 100; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            dw = 8'($urandom);
            drive(r, d, dw);
            check("random");
        end
    endtask

    task automatic test_wide();
        drive(1'b0, 1'b1, 8'h3C);
        check("wide_reset");
        drive(1'b1, 1'b1, 8'h3C);
        check("wide_load");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 8'hAA);
        check("b2b_a");
        drive(1'b0, 1'b1, 8'hAA);
        check("b2b_rst");
        drive(1'b1, 1'b1, 8'h55);
        check("b2b_release");
        drive(1'b1, 1'b0, 8'h00);
        check("b2b_zero");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        d1    = 1'b0;
        d8    = 8'h00;
        test_reset();
        test_load();
        test_glitch();
        test_sync_reset();
        test_random();
        test_wide();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
